// File: rtl/regfile_scb.sv
// Multi-port register file with a per-register busy scoreboard.
// Register 0 is hard-wired to zero; out-of-range addresses read as zero and are never written.
module regfile_scb #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      DEPTH     = 32,
   parameter int unsigned      ADDR_W    = 5,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter bit               BYPASS    = 1'b1
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] ra_a,
   input  logic [ADDR_W-1:0] ra_b,
   output logic [WIDTH-1:0]  rd_a,
   output logic [WIDTH-1:0]  rd_b,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic              busy_a,
   output logic              busy_b,
   output logic [DEPTH-1:0]  busy_vec
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return (a != '0) && ({1'b0, a} < DEPTH_L);
   endfunction

   logic [WIDTH-1:0] regs [1:DEPTH-1];
   logic [DEPTH-1:1] busy_q;
   logic             wr_ok;
   logic             rsv_ok;
   logic             fwd_a;
   logic             fwd_b;

   // Gating with clr keeps forwarding dead while reset is held.
   assign wr_ok  = we & ~clr & addr_ok(waddr);
   assign rsv_ok = rsv_en & ~clr & addr_ok(rsv_addr);
   assign fwd_a  = BYPASS & wr_ok & (ra_a == waddr);
   assign fwd_b  = BYPASS & wr_ok & (ra_b == waddr);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (wr_ok && (waddr == i[ADDR_W-1:0])) begin
               regs[i] <= wdata;
            end
         end
      end
   end

   // A reservation on the same edge as the write names a new producer, so set beats clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         busy_q <= '0;
      end else begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (rsv_ok && (rsv_addr == i[ADDR_W-1:0])) begin
               busy_q[i] <= 1'b1;
            end else if (wr_ok && (waddr == i[ADDR_W-1:0])) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   always_comb begin
      rd_a   = '0;
      rd_b   = '0;
      busy_a = 1'b0;
      busy_b = 1'b0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         if (ra_a == i[ADDR_W-1:0]) begin
            rd_a   = regs[i];
            busy_a = busy_q[i];
         end
         if (ra_b == i[ADDR_W-1:0]) begin
            rd_b   = regs[i];
            busy_b = busy_q[i];
         end
      end
      if (fwd_a) begin
         rd_a   = wdata;
         busy_a = 1'b0;
      end
      if (fwd_b) begin
         rd_b   = wdata;
         busy_b = 1'b0;
      end
   end

   assign busy_vec = {busy_q, 1'b0};

endmodule

// File: tb/tb_regfile_scb.sv
// Bench for regfile_scb: three configurations driven in parallel, checked against a
// behavioural model through an expected-value queue, plus hand-derived table values.
module tb_regfile_scb;

   logic        clk;
   logic        clr;
   logic        we;
   logic        rsv_en;
   logic [4:0]  waddr;
   logic [4:0]  ra_a;
   logic [4:0]  ra_b;
   logic [4:0]  rsv_addr;
   logic [31:0] wdata;

   logic [31:0] o_rd_a [3];
   logic [31:0] o_rd_b [3];
   logic        o_ba   [3];
   logic        o_bb   [3];
   logic [31:0] o_bv   [3];
   logic [31:0] bv_a;
   logic [31:0] bv_b;
   logic [19:0] bv_c;

   assign o_bv[0] = bv_a;
   assign o_bv[1] = bv_b;
   assign o_bv[2] = {12'd0, bv_c};

   regfile_scb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .RESET_VAL(32'd1), .BYPASS(1'b1)) u_a (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_a(ra_a), .ra_b(ra_b), .rd_a(o_rd_a[0]), .rd_b(o_rd_b[0]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(o_ba[0]), .busy_b(o_bb[0]), .busy_vec(bv_a));

   regfile_scb #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .RESET_VAL(32'd0), .BYPASS(1'b0)) u_b (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_a(ra_a), .ra_b(ra_b), .rd_a(o_rd_a[1]), .rd_b(o_rd_b[1]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(o_ba[1]), .busy_b(o_bb[1]), .busy_vec(bv_b));

   regfile_scb #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .RESET_VAL(32'd0), .BYPASS(1'b1)) u_c (
      .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .ra_a(ra_a), .ra_b(ra_b), .rd_a(o_rd_a[2]), .rd_b(o_rd_b[2]),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_a(o_ba[2]), .busy_b(o_bb[2]), .busy_vec(bv_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int          n_vec = 0;
   int          n_err = 0;
   int          cfg_depth [3] = '{32, 32, 20};
   logic [31:0] cfg_rv    [3] = '{32'd1, 32'd0, 32'd0};
   bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
   logic [31:0] m_reg     [3][32];
   bit          m_busy    [3][32];

   typedef struct {
      int          k;
      logic [31:0] rd_a;
      logic [31:0] rd_b;
      logic        ba;
      logic        bb;
      logic [31:0] bv;
   } exp_t;
   exp_t q[$];

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  ra_a;
      logic [4:0]  ra_b;
      logic        rsv_en;
      logic [4:0]  rsv_addr;
      logic [31:0] e_rd_a;
      logic [31:0] e_rd_b;
      logic        e_ba;
      logic        e_bb;
   } vec_t;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit mvalid(input int k, input logic [4:0] a);
      return (a != 5'd0) && (int'(a) < cfg_depth[k]);
   endfunction

   function automatic bit mfwd(input int k, input logic [4:0] a);
      return cfg_byp[k] && we && !clr && mvalid(k, waddr) && (waddr == a);
   endfunction

   function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
      if (!mvalid(k, a)) return 32'd0;
      if (mfwd(k, a)) return wdata;
      return m_reg[k][a];
   endfunction

   function automatic logic exp_busy(input int k, input logic [4:0] a);
      if (!mvalid(k, a)) return 1'b0;
      if (mfwd(k, a)) return 1'b0;
      return m_busy[k][a];
   endfunction

   function automatic logic [31:0] exp_bv(input int k);
      logic [31:0] v = '0;
      for (int i = 1; i < cfg_depth[k]; i++) v[i] = m_busy[k][i];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) begin
            m_reg[k][i]  = (i == 0) ? 32'd0 : cfg_rv[k];
            m_busy[k][i] = 1'b0;
         end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (we && mvalid(k, waddr)) begin
            m_reg[k][waddr]  = wdata;
            m_busy[k][waddr] = 1'b0;
         end
         if (rsv_en && mvalid(k, rsv_addr)) m_busy[k][rsv_addr] = 1'b1;
      end
   endtask

   task automatic sample(input string tag);
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         e.k    = k;
         e.rd_a = exp_rd(k, ra_a);
         e.rd_b = exp_rd(k, ra_b);
         e.ba   = exp_busy(k, ra_a);
         e.bb   = exp_busy(k, ra_b);
         e.bv   = exp_bv(k);
         q.push_back(e);
      end
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk($sformatf("%s.u%0d.rd_a", tag, e.k), o_rd_a[e.k], e.rd_a);
         chk($sformatf("%s.u%0d.rd_b", tag, e.k), o_rd_b[e.k], e.rd_b);
         chk($sformatf("%s.u%0d.busy_a", tag, e.k), {31'd0, o_ba[e.k]}, {31'd0, e.ba});
         chk($sformatf("%s.u%0d.busy_b", tag, e.k), {31'd0, o_bb[e.k]}, {31'd0, e.bb});
         chk($sformatf("%s.u%0d.busy_vec", tag, e.k), o_bv[e.k], e.bv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!clr) model_edge();
      @(negedge clk);
   endtask

   task automatic drive(input vec_t v);
      we = v.we; waddr = v.waddr; wdata = v.wdata;
      ra_a = v.ra_a; ra_b = v.ra_b; rsv_en = v.rsv_en; rsv_addr = v.rsv_addr;
   endtask

   initial begin
      // Hand-derived expectations for u_a (RESET_VAL=1, BYPASS=1, DEPTH=32), sampled before each edge.
      tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0, 1'b0, 5'd0,  32'hDEADBEEF, 32'd0,        1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd0, 1'b0, 5'd0,  32'hDEADBEEF, 32'd0,        1'b0, 1'b0};
      tbl[2]  = '{1'b0, 5'd0,  32'd0,        5'd3,  5'd5, 1'b1, 5'd3,  32'd1,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 5'd0,  32'd0,        5'd3,  5'd3, 1'b0, 5'd0,  32'd1,        32'd1,        1'b1, 1'b1};
      tbl[4]  = '{1'b1, 5'd3,  32'h00000033, 5'd3,  5'd4, 1'b0, 5'd0,  32'h33,       32'd1,        1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'd0,  32'd0,        5'd3,  5'd3, 1'b0, 5'd0,  32'h33,       32'h33,       1'b0, 1'b0};
      tbl[6]  = '{1'b1, 5'd3,  32'h00000044, 5'd3,  5'd6, 1'b1, 5'd3,  32'h44,       32'd1,        1'b0, 1'b0};
      tbl[7]  = '{1'b0, 5'd0,  32'd0,        5'd3,  5'd3, 1'b0, 5'd0,  32'h44,       32'h44,       1'b1, 1'b1};
      tbl[8]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd8,  5'd7, 1'b1, 5'd8,  32'd1,        32'hA5A5A5A5, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 5'd8,  32'h00000088, 5'd8,  5'd7, 1'b1, 5'd7,  32'h88,       32'hA5A5A5A5, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 5'd0,  32'd0,        5'd8,  5'd7, 1'b1, 5'd0,  32'h88,       32'hA5A5A5A5, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 5'd25, 32'h00000BAD, 5'd25, 5'd0, 1'b1, 5'd25, 32'hBAD,      32'd0,        1'b0, 1'b0};
      tbl[12] = '{1'b0, 5'd0,  32'd0,        5'd25, 5'd3, 1'b0, 5'd0,  32'hBAD,      32'h44,       1'b1, 1'b1};
      tbl[13] = '{1'b0, 5'd0,  32'd0,        5'd31, 5'd0, 1'b0, 5'd0,  32'd1,        32'd0,        1'b0, 1'b0};

      clr = 1'b1; we = 1'b0; rsv_en = 1'b0; waddr = '0; wdata = '0;
      ra_a = '0; ra_b = 5'd1; rsv_addr = '0;
      model_reset();
      @(negedge clk);
      clr = 1'b0;
      sample("rst");

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i]);
         sample($sformatf("v%0d", i));
         chk($sformatf("tbl%0d.rd_a", i), o_rd_a[0], tbl[i].e_rd_a);
         chk($sformatf("tbl%0d.rd_b", i), o_rd_b[0], tbl[i].e_rd_b);
         chk($sformatf("tbl%0d.busy_a", i), {31'd0, o_ba[0]}, {31'd0, tbl[i].e_ba});
         chk($sformatf("tbl%0d.busy_b", i), {31'd0, o_bb[0]}, {31'd0, tbl[i].e_bb});
         step();
      end

      // Reset arriving mid-cycle with a write and a reservation pending.
      we = 1'b1; waddr = 5'd4; wdata = 32'h77; rsv_en = 1'b1; rsv_addr = 5'd9;
      ra_a = 5'd4; ra_b = 5'd9;
      sample("m0");
      step();
      waddr = 5'd4; wdata = 32'h99; rsv_addr = 5'd10;
      sample("m1");
      clr = 1'b1;
      model_reset();
      sample("m2");
      chk("m2.u0.rd_a_resetval", o_rd_a[0], 32'd1);
      chk("m2.u0.busy_vec_clear", bv_a, 32'd0);
      step();
      sample("m3");
      we = 1'b0; rsv_en = 1'b0; clr = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ra_a = 5'(a);
         ra_b = 5'(31 - a);
         sample($sformatf("sweep%0d", a));
         @(negedge clk);
      end

      // First edge after reset release behaves normally.
      we = 1'b1; waddr = 5'd4; wdata = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd9;
      ra_a = 5'd4; ra_b = 5'd9;
      sample("p0");
      step();
      we = 1'b0; rsv_en = 1'b0;
      sample("p1");
      chk("p1.u0.rd_a_written", o_rd_a[0], 32'h55);
      chk("p1.u0.busy_b_set", {31'd0, o_bb[0]}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
